// File: rtl/register_queue.sv
// Elastic register stage: DEPTH-word circular buffer with valid/ready on both
// sides, occupancy/full/empty status and a synchronous flush.
module register_queue #(
    parameter int REGISTER_LENGTH = 32,
    parameter int DEPTH           = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [REGISTER_LENGTH-1:0]   input_to_register,
    input  logic                         input_valid,
    output logic                         input_ready,
    output logic [REGISTER_LENGTH-1:0]   outputRegister,
    output logic                         output_valid,
    input  logic                         output_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [REGISTER_LENGTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]           wr_ptr_r;
    logic [PTR_W-1:0]           rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic                       push_s;
    logic                       pop_s;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Status and handshakes, all derived from registered state only.
    always_comb begin
        full         = (count_r == FULL_CNT);
        empty        = (count_r == {CNT_W{1'b0}});
        occupancy    = count_r;
        input_ready  = ~full & ~reset;
        output_valid = ~empty;
        push_s       = input_valid & input_ready;
        pop_s        = output_valid & output_ready;
        if (output_valid) begin
            outputRegister = mem_r[rd_ptr_r];
        end else begin
            outputRegister = {REGISTER_LENGTH{1'b0}};
        end
    end

    // Pointer and occupancy state; flush overrides any handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Word storage; cleared by reset but deliberately left intact by flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {REGISTER_LENGTH{1'b0}};
            end
        end else if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= input_to_register;
        end
    end

endmodule

// File: tb/tb_register_queue.sv
// Self-checking bench for register_queue: directed vector table, hand-written
// corner sequences and randomized traffic checked against a queue model.
module tb_register_queue;

    localparam int DEPTH = 4;
    localparam int W     = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [W-1:0]  input_to_register = 32'h0;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [W-1:0]  outputRegister;
    logic          output_valid;
    logic          output_ready = 1'b0;
    logic [2:0]    occupancy;
    logic          full;
    logic          empty;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] model_q[$];

    register_queue #(.REGISTER_LENGTH(W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .input_to_register(input_to_register), .input_valid(input_valid),
        .input_ready(input_ready), .outputRegister(outputRegister),
        .output_valid(output_valid), .output_ready(output_ready),
        .occupancy(occupancy), .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         fl;
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        int           occ;
        logic [W-1:0] out;
        logic         ov;
        logic         fu;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock edge; the model applies the handshake rules seen before the edge.
    task automatic step();
        bit           acc;
        bit           pp;
        logic [W-1:0] d;
        acc = input_valid && (model_q.size() < DEPTH);
        pp  = output_ready && (model_q.size() > 0);
        d   = input_to_register;
        @(posedge clock);
        if (flush) begin
            model_q.delete();
        end else begin
            if (pp) void'(model_q.pop_front());
            if (acc) model_q.push_back(d);
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [W-1:0] head;
        head = (model_q.size() > 0) ? model_q[0] : 32'h0;
        chk({tag, "_occ"},   {29'h0, occupancy},    model_q.size());
        chk({tag, "_out"},   outputRegister,        head);
        chk({tag, "_ovld"},  {31'h0, output_valid}, {31'h0, model_q.size() > 0});
        chk({tag, "_full"},  {31'h0, full},         {31'h0, model_q.size() == DEPTH});
        chk({tag, "_empty"}, {31'h0, empty},        {31'h0, model_q.size() == 0});
        chk({tag, "_irdy"},  {31'h0, input_ready},  {31'h0, model_q.size() < DEPTH});
    endtask

    task automatic idle();
        flush        = 1'b0;
        input_valid  = 1'b0;
        output_ready = 1'b0;
    endtask

    initial begin
        // fill, overfill, drain in order
        vecs[0]  = '{1'b0, 1'b1, 32'h11111111, 1'b0, 1, 32'h11111111, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h22222222, 1'b0, 2, 32'h11111111, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h33333333, 1'b0, 3, 32'h11111111, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h44444444, 1'b0, 4, 32'h11111111, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'h55555555, 1'b0, 4, 32'h11111111, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 3, 32'h22222222, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 2, 32'h33333333, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1, 32'h44444444, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 32'h0,        1'b0, 1'b0};
        // refill, then push+pop while full is pop only
        vecs[9]  = '{1'b0, 1'b1, 32'hA1,       1'b0, 1, 32'hA1,       1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'hA2,       1'b0, 2, 32'hA1,       1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'hA3,       1'b0, 3, 32'hA1,       1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'hA4,       1'b0, 4, 32'hA1,       1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 32'hAA,       1'b1, 3, 32'hA2,       1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 32'hAA,       1'b0, 4, 32'hA2,       1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 3, 32'hA3,       1'b1, 1'b0};
        // flush beats push; push right after flush is accepted
        vecs[16] = '{1'b1, 1'b1, 32'hBB,       1'b1, 0, 32'h0,        1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 0, 32'h0,        1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 32'hCC,       1'b0, 1, 32'hCC,       1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 32'h0,        1'b0, 1'b0};

        // reset values, asynchronous from time zero
        #3;
        chk("rst_irdy",  {31'h0, input_ready},  32'h0);
        chk("rst_ovld",  {31'h0, output_valid}, 32'h0);
        chk("rst_occ",   {29'h0, occupancy},    32'h0);
        chk("rst_full",  {31'h0, full},         32'h0);
        chk("rst_empty", {31'h0, empty},        32'h1);
        chk("rst_out",   outputRegister,        32'h0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1 chk("rel_irdy", {31'h0, input_ready}, 32'h1);

        for (int i = 0; i < 20; i++) begin
            flush             = vecs[i].fl;
            input_valid       = vecs[i].iv;
            input_to_register = vecs[i].d;
            output_ready      = vecs[i].ordy;
            step();
            chk($sformatf("vec%0d_occ", i),  {29'h0, occupancy},    vecs[i].occ);
            chk($sformatf("vec%0d_out", i),  outputRegister,        vecs[i].out);
            chk($sformatf("vec%0d_ovld", i), {31'h0, output_valid}, {31'h0, vecs[i].ov});
            chk($sformatf("vec%0d_full", i), {31'h0, full},         {31'h0, vecs[i].fu});
        end
        idle();

        // streaming across pointer wrap at constant occupancy 2
        input_valid = 1'b1;
        input_to_register = 32'd0;
        step();
        input_to_register = 32'd1;
        step();
        for (int i = 0; i < 10; i++) begin
            input_to_register = 32'(i + 2);
            output_ready      = 1'b1;
            chk($sformatf("stream%0d_out", i), outputRegister, 32'(i));
            step();
            chk($sformatf("stream%0d_occ", i), {29'h0, occupancy}, 32'd2);
        end
        chk_model("stream_end");
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_model("stream_flush");

        // asynchronous reset between edges at occupancy 2
        input_valid = 1'b1;
        input_to_register = 32'h0000_0E01;
        step();
        input_to_register = 32'h0000_0E02;
        step();
        idle();
        chk("pre_rst_occ", {29'h0, occupancy}, 32'd2);
        #2 reset = 1'b1;
        #1;
        model_q.delete();
        chk("amid_ovld", {31'h0, output_valid}, 32'h0);
        chk("amid_occ",  {29'h0, occupancy},    32'h0);
        chk("amid_irdy", {31'h0, input_ready},  32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        input_valid = 1'b1;
        input_to_register = 32'h0000_0077;
        step();
        input_valid = 1'b0;
        chk("post_rst_out", outputRegister, 32'h0000_0077);
        chk_model("post_rst");

        // randomized traffic: first biased toward filling, then toward draining
        for (int k = 0; k < 400; k++) begin
            flush             = ($urandom_range(0, 24) == 0);
            input_valid       = $urandom_range(0, 1) == 1;
            input_to_register = $urandom;
            output_ready      = (k < 200) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 3) != 0);
            step();
            chk_model($sformatf("rnd%0d", k));
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
